// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   DefaultXlen / DefaultNregs : default data width and register count
//   rf_state_t                 : sweep controller states
//   field_lsb()                : LSB of port field idx in a flat packed bus
package regfile_pkg;

  localparam int unsigned DefaultXlen  = 32;
  localparam int unsigned DefaultNregs = 32;

  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

  // Ports are packed flat: port idx occupies [idx*width +: width].
  function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port resolution for one queried address.
// Reports whether any allowed, enabled write port targets i_addr and, if so, the data of the
// highest-numbered such port. Used per register for the write path and per read port for bypass.
//   i_addr    : address being resolved
//   i_allow   : writes are accepted this cycle (idle and no clear request)
//   i_wr_en   : per-port write enables
//   i_wr_addr : packed write addresses
//   i_wr_data : packed write data
//   o_hit     : an effective write targets i_addr
//   o_data    : data of the winning port (0 when no hit)
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = DefaultXlen,
  parameter int unsigned AW       = 5,
  parameter int unsigned NWR      = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic [AW-1:0]       i_addr,
  input  logic                i_allow,
  input  logic [NWR-1:0]      i_wr_en,
  input  logic [NWR*AW-1:0]   i_wr_addr,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  output logic                o_hit,
  output logic [XLEN-1:0]     o_data
);

  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    // Ascending scan: a later (higher-numbered) match overrides earlier ones.
    for (int unsigned p = 0; p < NWR; p++) begin
      if (i_allow && i_wr_en[p] && (i_wr_addr[field_lsb(p, AW) +: AW] == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_wr_data[field_lsb(p, XLEN) +: XLEN];
      end
    end
    // Writes to a hardwired zero register are discarded, so they never hit.
    if ((ZERO_REG != 0) && (i_addr == '0)) begin
      o_hit  = 1'b0;
      o_data = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with clear sweep.
// After reset (or a clear request) the file is swept to zero one register per cycle; while the
// sweep runs writes are ignored and all read ports return 0.
//   i_clk       : clock, rising edge
//   i_reset     : asynchronous active-low reset, restarts the sweep
//   i_rd_addr   : packed read addresses, port i at [i*AW +: AW]
//   o_rd_data   : packed read data, port i at [i*XLEN +: XLEN]
//   i_wr_en     : per-port write enables
//   i_wr_addr   : packed write addresses
//   i_wr_data   : packed write data
//   i_clear_req : one-cycle pulse starting a sweep
//   o_busy      : sweep in progress
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = DefaultXlen,
  parameter int unsigned NREGS    = DefaultNregs,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NRD*AW-1:0]   i_rd_addr,
  output logic [NRD*XLEN-1:0] o_rd_data,
  input  logic [NWR-1:0]      i_wr_en,
  input  logic [NWR*AW-1:0]   i_wr_addr,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  input  logic                i_clear_req,
  output logic                o_busy
);

  rf_state_t       r_state, w_state_d;
  logic [AW-1:0]   r_clr_idx, w_clr_idx_d;
  logic [XLEN-1:0] r_regs [NREGS];

  logic            w_busy;
  logic            w_wr_allow;
  logic [NREGS-1:0] w_reg_hit;
  logic [XLEN-1:0] w_reg_wdata [NREGS];

  // ---------------------------------------------------------------------------
  // Sweep controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= RF_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_d;
      r_clr_idx <= w_clr_idx_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_clr_idx_d = r_clr_idx;
    case (r_state)
      RF_IDLE: begin
        if (i_clear_req) begin
          w_state_d   = RF_CLEAR;
          w_clr_idx_d = '0;
        end
      end
      RF_CLEAR: begin
        w_clr_idx_d = r_clr_idx + 1'b1;
        if (r_clr_idx == AW'(NREGS - 1)) begin
          w_state_d = RF_IDLE;
        end
      end
      default: w_state_d = RF_CLEAR;
    endcase
  end

  assign w_busy     = (r_state == RF_CLEAR);
  assign o_busy     = w_busy;
  // A clear request wins over same-cycle writes; those writes are dropped and not bypassed.
  assign w_wr_allow = (r_state == RF_IDLE) && !i_clear_req;

  // ---------------------------------------------------------------------------
  // Write path: one resolver per register
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < NREGS; j++) begin : g_wr
    regfile_wr_arb #(
      .XLEN    (XLEN),
      .AW      (AW),
      .NWR     (NWR),
      .ZERO_REG(ZERO_REG)
    ) u_wr_arb (
      .i_addr   (AW'(j)),
      .i_allow  (w_wr_allow),
      .i_wr_en  (i_wr_en),
      .i_wr_addr(i_wr_addr),
      .i_wr_data(i_wr_data),
      .o_hit    (w_reg_hit[j]),
      .o_data   (w_reg_wdata[j])
    );
  end

  // Array has no reset; the sweep is what initialises it.
  always_ff @(posedge i_clk) begin
    for (int unsigned j = 0; j < NREGS; j++) begin
      if (w_busy && (r_clr_idx == AW'(j))) begin
        r_regs[j] <= '0;
      end else if (w_reg_hit[j]) begin
        r_regs[j] <= w_reg_wdata[j];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: combinational, with optional same-cycle bypass
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   w_raddr;
    logic            w_rd_hit;
    logic [XLEN-1:0] w_rd_byp;
    logic [XLEN-1:0] w_rdata;

    assign w_raddr = i_rd_addr[field_lsb(i, AW) +: AW];

    regfile_wr_arb #(
      .XLEN    (XLEN),
      .AW      (AW),
      .NWR     (NWR),
      .ZERO_REG(ZERO_REG)
    ) u_rd_arb (
      .i_addr   (w_raddr),
      .i_allow  (w_wr_allow),
      .i_wr_en  (i_wr_en),
      .i_wr_addr(i_wr_addr),
      .i_wr_data(i_wr_data),
      .o_hit    (w_rd_hit),
      .o_data   (w_rd_byp)
    );

    always_comb begin
      w_rdata = r_regs[w_raddr];
      if ((BYPASS != 0) && w_rd_hit) begin
        w_rdata = w_rd_byp;
      end
      if (w_busy || ((ZERO_REG != 0) && (w_raddr == '0))) begin
        w_rdata = '0;
      end
    end

    assign o_rd_data[field_lsb(i, XLEN) +: XLEN] = w_rdata;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp. Two instances share one stimulus stream:
//   dut_a : NWR=2, BYPASS=1
//   dut_b : NWR=1 (sees write port 0 only), BYPASS=0
// Expectations come from a plain array model of the register contents plus a sweep counter.
module tb_regfile_mp;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int XLEN  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2*AW-1:0]   rd_addr;
  logic [1:0]        wr_en;
  logic [2*AW-1:0]   wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic              clear_req;
  logic [2*XLEN-1:0] rd_a, rd_b;
  logic              busy_a, busy_b;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)
  ) dut_a (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_a),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_clear_req(clear_req),
    .o_busy     (busy_a)
  );

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(1), .BYPASS(0), .ZERO_REG(1)
  ) dut_b (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_b),
    .i_wr_en    (wr_en[0:0]),
    .i_wr_addr  (wr_addr[AW-1:0]),
    .i_wr_data  (wr_data[XLEN-1:0]),
    .i_clear_req(clear_req),
    .o_busy     (busy_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register contents and number of sweep cycles still to run.
  logic [31:0] ma [NREGS];
  logic [31:0] mb [NREGS];
  int          sweep_left;

  function automatic logic [31:0] exp_a(input int port);
    logic [AW-1:0] a;
    logic [31:0]   v;
    a = rd_addr[port*AW +: AW];
    if (sweep_left > 0 || a == 0) return 32'h0;
    v = ma[a];
    if (!clear_req)
      for (int p = 0; p < 2; p++)
        if (wr_en[p] && wr_addr[p*AW +: AW] == a) v = wr_data[p*XLEN +: XLEN];
    return v;
  endfunction

  function automatic logic [31:0] exp_b(input int port);
    logic [AW-1:0] a;
    a = rd_addr[port*AW +: AW];
    if (sweep_left > 0 || a == 0) return 32'h0;
    return mb[a];
  endfunction

  // Advance one rising edge and apply its effect to the model; returns at edge+1.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      sweep_left = NREGS;
    end else if (sweep_left > 0) begin
      sweep_left--;
      if (sweep_left == 0)
        for (int r = 0; r < NREGS; r++) begin
          ma[r] = 32'h0;
          mb[r] = 32'h0;
        end
    end else if (clear_req) begin
      sweep_left = NREGS;
    end else begin
      for (int p = 0; p < 2; p++)
        if (wr_en[p] && wr_addr[p*AW +: AW] != 0)
          ma[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
      if (wr_en[0] && wr_addr[AW-1:0] != 0) mb[wr_addr[AW-1:0]] = wr_data[XLEN-1:0];
    end
    #1;
  endtask

  task automatic idle_inputs();
    wr_en     = 2'b00;
    wr_addr   = '0;
    wr_data   = '0;
    clear_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sweep_left = NREGS;
    rd_addr = '0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < NREGS; c++) begin
      rd_addr = 10'($urandom);
      wr_en   = 2'($urandom);
      wr_addr = 10'($urandom);
      wr_data = {$urandom, $urandom};
      #1;
      n_checks++;
      if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_busy cyc %0d: got a=%b b=%b expected 1", c, busy_a, busy_b);
      end
      n_checks++;
      if (rd_a !== 64'h0 || rd_b !== 64'h0) begin
        n_errors++;
        $display("FAIL reset_rd_zero cyc %0d: got a=%h b=%h expected 0", c, rd_a, rd_b);
      end
      tick();
    end
    idle_inputs();
    #1;
    n_checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_busy_end: got a=%b b=%b expected 0", busy_a, busy_b);
    end
    for (int r = 1; r < NREGS; r += 2) begin
      rd_addr = {5'(r + 1), 5'(r)};
      #1;
      n_checks++;
      if (rd_a !== 64'h0 || rd_b !== 64'h0) begin
        n_errors++;
        $display("FAIL reset_cleared r%0d: got a=%h b=%h expected 0", r, rd_a, rd_b);
      end
    end
  endtask

  task automatic test_bypass();
    rd_addr = {5'd9, 5'd5};
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd5};
    wr_data = {32'h0, 32'hDEADBEEF};
    #1;
    n_checks++;
    if (rd_a[31:0] !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL bypass_same_cycle: got %h expected deadbeef", rd_a[31:0]);
    end
    n_checks++;
    if (rd_b[31:0] !== 32'h0) begin
      n_errors++;
      $display("FAIL nobypass_old: got %h expected 0", rd_b[31:0]);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_a[31:0] !== 32'hDEADBEEF || rd_b[31:0] !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL bypass_next_cycle: got a=%h b=%h expected deadbeef", rd_a[31:0],
               rd_b[31:0]);
    end
  endtask

  task automatic test_conflict();
    rd_addr = {5'd7, 5'd7};
    wr_en   = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {32'h22, 32'h11};
    #1;
    n_checks++;
    if (rd_a !== {32'h22, 32'h22}) begin
      n_errors++;
      $display("FAIL conflict_bypass: got %h expected 22 on both ports", rd_a);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_a[31:0] !== 32'h22) begin
      n_errors++;
      $display("FAIL conflict_stored: got %h expected 22", rd_a[31:0]);
    end
    n_checks++;
    if (rd_b[31:0] !== 32'h11) begin
      n_errors++;
      $display("FAIL single_port_stored: got %h expected 11", rd_b[31:0]);
    end
  endtask

  task automatic test_zero_reg();
    rd_addr = {5'd0, 5'd0};
    wr_en   = 2'b11;
    wr_addr = {5'd0, 5'd0};
    wr_data = {32'hFFFFFFFF, 32'hFFFFFFFF};
    #1;
    n_checks++;
    if (rd_a !== 64'h0 || rd_b !== 64'h0) begin
      n_errors++;
      $display("FAIL zero_reg_same: got a=%h b=%h expected 0", rd_a, rd_b);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_a !== 64'h0 || rd_b !== 64'h0) begin
      n_errors++;
      $display("FAIL zero_reg_after: got a=%h b=%h expected 0", rd_a, rd_b);
    end
  endtask

  task automatic test_clear_req();
    int cnt;
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd3};
    wr_data = {32'h0, 32'hA5A5A5A5};
    tick();
    idle_inputs();
    rd_addr = {5'd4, 5'd3};
    #1;
    n_checks++;
    if (rd_a[31:0] !== 32'hA5A5A5A5 || rd_b[31:0] !== 32'hA5A5A5A5) begin
      n_errors++;
      $display("FAIL clear_fill: got a=%h b=%h expected a5a5a5a5", rd_a[31:0], rd_b[31:0]);
    end
    clear_req = 1'b1;
    wr_en     = 2'b01;
    wr_addr   = {5'd0, 5'd4};
    wr_data   = {32'h0, 32'h12345678};
    tick();
    idle_inputs();
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    n_checks++;
    if (cnt != NREGS) begin
      n_errors++;
      $display("FAIL clear_busy_len: got %0d cycles expected %0d", cnt, NREGS);
    end
    #1;
    n_checks++;
    if (rd_a !== 64'h0 || rd_b !== 64'h0) begin
      n_errors++;
      $display("FAIL clear_result: got a=%h b=%h expected 0", rd_a, rd_b);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd12};
    wr_data = {32'h0, 32'hCAFEF00D};
    tick();
    idle_inputs();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    sweep_left = NREGS;
    #1;
    n_checks++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_busy: got a=%b b=%b expected 1", busy_a, busy_b);
    end
    tick();
    rst_n = 1'b1;
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    n_checks++;
    if (cnt != NREGS) begin
      n_errors++;
      $display("FAIL reset_mid_len: got %0d cycles expected %0d", cnt, NREGS);
    end
    rd_addr = {5'd12, 5'd31};
    #1;
    n_checks++;
    if (rd_a !== 64'h0 || rd_b !== 64'h0) begin
      n_errors++;
      $display("FAIL reset_mid_result: got a=%h b=%h expected 0", rd_a, rd_b);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rd_addr   = ($urandom_range(0, 1) == 0) ? 10'($urandom) : {5'($urandom_range(0, 7)),
                                                                  5'($urandom_range(0, 7))};
      wr_en     = 2'($urandom);
      wr_addr   = ($urandom_range(0, 1) == 0) ? 10'($urandom) : {5'($urandom_range(0, 7)),
                                                                  5'($urandom_range(0, 7))};
      wr_data   = {$urandom, $urandom};
      clear_req = ($urandom_range(0, 99) == 0);
      #1;
      n_checks++;
      if (busy_a !== (sweep_left > 0) || busy_b !== (sweep_left > 0)) begin
        n_errors++;
        $display("FAIL rand_busy cyc %0d: got a=%b b=%b expected %b", c, busy_a, busy_b,
                 sweep_left > 0);
      end
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (rd_a[p*XLEN +: XLEN] !== exp_a(p)) begin
          n_errors++;
          $display("FAIL rand_rd_a cyc %0d port %0d: got %h expected %h", c, p,
                   rd_a[p*XLEN +: XLEN], exp_a(p));
        end
        n_checks++;
        if (rd_b[p*XLEN +: XLEN] !== exp_b(p)) begin
          n_errors++;
          $display("FAIL rand_rd_b cyc %0d port %0d: got %h expected %h", c, p,
                   rd_b[p*XLEN +: XLEN], exp_b(p));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) begin
      ma[r] = 'x;
      mb[r] = 'x;
    end
    test_reset();
    test_bypass();
    test_conflict();
    test_zero_reg();
    test_clear_req();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the core's single-write/dual-read register file.
- Sits between decode (read ports) and writeback (write ports) of the single-cycle core; sized to also serve dual-issue experiments.
- Adds configurable width/depth/port counts, optional same-cycle write-to-read bypass, deterministic write-port priority, and a sequential clear sweep. The sweep replaces file preloading and runs after reset or on request.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREGS), address width; derived, not overridden.
- NRD, 2, number of read ports.
- NWR, 1, number of write ports.
- BYPASS, 1, 1 = a read returns the same-cycle write data; 0 = a read returns stored contents.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- wr_en  in  NWR  per-port write enable, active-high.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- clear_req  in  1  one-cycle pulse; starts a clear sweep.
- busy  out  1  high while the sweep is in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to CLEAR, clr_idx=0, busy=1.
  - Array contents are not touched by reset itself.
  - rd_data reads 0 while busy (see read path).
- FSM states IDLE and CLEAR:
  - CLEAR: each rising edge writes 0 to registers[clr_idx], then clr_idx increments.
  - When clr_idx==NREGS-1 is written, go to IDLE and deassert busy on the next cycle.
  - A full sweep takes exactly NREGS cycles after reset release.
  - IDLE: clear_req=1 sets clr_idx=0 and moves to CLEAR, with busy=1 from the next cycle.
- During CLEAR:
  - wr_en is ignored and clear_req is ignored.
  - All rd_data ports drive 0.
  - The reset-to-CLEAR sequence restarts if reset is reasserted mid-sweep.
- Write path (IDLE only):
  - On a rising edge, for each port with wr_en=1, registers[wr_addr] <= wr_data.
  - Writes to address 0 are discarded when ZERO_REG=1.
  - Same-address conflict: the highest-numbered enabled port wins, deterministically. Lower ports are dropped without error.
  - A clear_req in the same cycle as writes takes priority: the writes are dropped and CLEAR is entered.
- Read path: combinational, zero latency.
  - rd_data[i] = 0 if busy, or if ZERO_REG=1 and rd_addr[i]==0.
  - Otherwise, if BYPASS=1 and an enabled write port targets rd_addr[i] this cycle, output that port's wr_data; the highest-numbered matching port wins.
  - Otherwise output registers[rd_addr[i]].
- Bypass does not apply to discarded writes: address 0 with ZERO_REG=1, or any write during CLEAR.
- X-free: no read may return uninitialised array contents after the first sweep completes.

Decomposition:
- Shared package regfile_pkg:
  - constants for default XLEN/NREGS;
  - state enum rf_state_t {RF_IDLE, RF_CLEAR};
  - helper function for extracting port field slices.
- One sub-module, regfile_wr_arb: per-address write-port priority resolution plus bypass match. It is reused by both the write path and the read path.

Test Plan:
- Reset release, no stimulus -> busy=1 for exactly 32 cycles, then 0; all rd_data=0 throughout; registers 1..31 read 0 afterwards.
- IDLE, wr_en[0]=1, addr 5, data 32'hDEADBEEF; rd_addr0=5 in the same cycle:
  - BYPASS=1 -> rd_data0=DEADBEEF in the same cycle.
  - BYPASS=0 -> old value 0, then DEADBEEF in the next cycle.
- NWR=2, both ports write addr 7 with 32'h11 (port0) and 32'h22 (port1) -> registers[7]=32'h22; same-cycle bypass returns 32'h22.
- Write addr 0 with 32'hFFFFFFFF, ZERO_REG=1 -> rd_data for addr 0 is 0 in the same cycle and afterwards.
- Fill reg 3 = 32'hA5A5A5A5, pulse clear_req together with a write to reg 4 -> write dropped; busy high 32 cycles; reg 3 and reg 4 read 0 afterwards.
- Assert reset at sweep cycle 10 for 1 cycle -> sweep restarts at clr_idx=0; busy stays high for a full 32 cycles after release.
